wb_sched: RTL and testbench
===========================

# wb_sched

Writeback scheduler for the RISC-V core's single register-file write port. It accepts ALU results and variable-latency load returns, decides each cycle which source writes back, and drives the memory-to-register select and both data inputs of the downstream writeback mux. It tracks one outstanding load, holds colliding ALU results in a small buffer, and back-pressures the pipeline with `stall`.

## Interface
- `DATA_WIDTH`, default `DATA_WIDTH from defs.vh (32): width of the ALU result and memory data.
- `DEPTH`, default 2: ALU result buffer entries (power of two, ≥2).
- `TIMEOUT`, default 16: maximum cycles to wait for `mem_valid` after a load issue.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_valid`  in  1  ALU result offered this cycle.
- `alu_rd`  in  5  destination register of the ALU result.
- `alu_result`  in  DATA_WIDTH  ALU result.
- `load_issue`  in  1  load sent to memory this cycle.
- `load_rd`  in  5  destination register of the load.
- `mem_valid`  in  1  load data returned this cycle.
- `mem_data`  in  DATA_WIDTH  returned load data.
- `stall`  out  1  combinational; offered request(s) not accepted this cycle.
- `RegWrite`  out  1  register-file write enable, registered.
- `MemtoReg`  out  1  mux select: 1 selects memory data, 0 selects ALU result. Registered.
- `wb_rd`  out  5  write address, registered.
- `wb_alu_result`  out  DATA_WIDTH  mux ALU input, registered.
- `wb_mem_data`  out  DATA_WIDTH  mux memory input, registered.
- `mem_err`  out  1  sticky error flag, registered.

## Operation
- FSM states:
  - `IDLE`: no load outstanding.
  - `WAIT_MEM`: one load outstanding. Holds `pend_rd` and a cycle counter.
- `IDLE` → `WAIT_MEM` on an accepted `load_issue`. This latches `pend_rd = load_rd` and clears the counter.
- `WAIT_MEM` → `IDLE` on `mem_valid`. The load is scheduled for writeback.
- `WAIT_MEM` → `IDLE` on timeout, when the counter reaches `TIMEOUT-1` with no `mem_valid`. No writeback occurs and `mem_err` is set.
- `mem_valid` while in `IDLE` is spurious: the data is ignored and `mem_err` is set.
- `stall` is the OR of:
  - `load_issue` while in `WAIT_MEM`.
  - `alu_valid` while the buffer holds DEPTH entries.
  - WAW hazard: `alu_valid` in `WAIT_MEM` with `alu_rd == pend_rd` and `alu_rd != 0`.
- While `stall`=1, neither request is accepted. Upstream holds its inputs stable.
- When `stall`=0, `alu_valid` and `load_issue` may both be accepted in the same cycle.
- Write-port priority at each edge:
  1. Load return (`mem_valid` in `WAIT_MEM`).
  2. Buffer head.
  3. ALU result accepted this cycle, bypassing the buffer only if the buffer is empty.
  4. No write.
- An accepted ALU result that does not win the port is pushed into the buffer. Buffer order is FIFO.
- Writes to register 0:
  - An ALU result with `alu_rd == 0` is accepted but dropped: never buffered, never written.
  - A load with `load_rd == 0` still goes through the FSM normally, but its writeback is suppressed.
- Winning a load writes `MemtoReg`=1, `wb_mem_data=mem_data`, `wb_rd=pend_rd`.
- Winning an ALU result writes `MemtoReg`=0 and `wb_alu_result`, `wb_rd` from that entry.
- The data output not selected in a cycle holds its previous value.
- `mem_err` clears only on reset.

## Timing
- Reset (`rst_n`=0, asynchronous): state `IDLE`, buffer empty, counter 0. All outputs 0: `RegWrite`, `MemtoReg`, `wb_rd`, `wb_alu_result`, `wb_mem_data`, `mem_err`.
- `stall` is 0 in reset unless `alu_valid`/`load_issue` conditions apply. With an empty buffer in `IDLE`, `stall`=0.
- Reset mid-operation drops the outstanding load and all buffered results, with no write.
- ALU latency: accepted at edge N, empty buffer, no load return → `RegWrite`=1 in the cycle after edge N.
- Load latency: `mem_valid` sampled at edge M → `RegWrite`=1, `MemtoReg`=1 in the cycle after edge M.
- `RegWrite` is high for exactly one cycle per write.
- Timeout: `load_issue` at edge K with no `mem_valid` → `IDLE` and `mem_err`=1 after edge K+TIMEOUT.
- `mem_valid` on the same edge as the counter reaching `TIMEOUT-1`: the return wins and no error is raised.

## Test plan
- Reset then ALU only: `alu_valid`, `alu_rd`=5, `alu_result`=11 → next cycle `RegWrite`=1, `MemtoReg`=0, `wb_rd`=5, `wb_alu_result`=11.
- Load: `load_issue`, `load_rd`=7; 3 cycles later `mem_valid`, `mem_data`=11111 → `RegWrite`=1, `MemtoReg`=1, `wb_rd`=7, `wb_mem_data`=11111.
- Collision: `mem_valid` (rd 7, data 11111) in the same cycle as ALU (rd 3, result 42) → load written first. The next cycle writes ALU rd 3 = 42 with `MemtoReg`=0.
- Buffer full:
  - Hold the port with back-to-back collisions until 2 ALU results are buffered.
  - A third `alu_valid` → `stall`=1 and the third is not accepted.
  - The buffer drains in FIFO order.
- Hazards:
  - `load_issue` in `WAIT_MEM` → `stall`=1.
  - ALU rd equal to `pend_rd` → `stall`=1 until the return.
  - ALU with rd 0 → no `RegWrite`.
- Timeout and reset:
  - No `mem_valid` for 16 cycles → `mem_err`=1, `IDLE`, no write.
  - Spurious `mem_valid` in `IDLE` → `mem_err`=1.
  - `rst_n` low mid-`WAIT_MEM` → all outputs 0 immediately.

Source files
------------

// File: rtl/wb_sched.sv
// wb_sched: writeback scheduler for the single register-file write port.
// Arbitrates load returns, buffered ALU results and fresh ALU results.
module wb_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  load_issue,
    input  logic [4:0]            load_rd,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  stall,
    output logic                  RegWrite,
    output logic                  MemtoReg,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_alu_result,
    output logic [DATA_WIDTH-1:0] wb_mem_data,
    output logic                  mem_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [4:0]            pend_rd;
    logic [CW-1:0]         cnt;

    logic [4:0]            buf_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] buf_data [DEPTH];
    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    logic [AW:0]           count;

    logic busy;
    logic buf_empty;
    logic buf_full;
    logic load_acc;
    logic alu_keep;
    logic load_ret;
    logic timeout_hit;
    logic spurious;
    logic win_load;
    logic win_head;
    logic win_alu;
    logic push;

    assign busy      = (state == WAIT_MEM);
    assign buf_empty = (count == '0);
    assign buf_full  = (count == FULL_CNT);

    // FSM state register plus the outstanding-load tag and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend_rd <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (!busy && load_acc) begin
                pend_rd <= load_rd;
                cnt     <= '0;
            end else if (busy) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Next state: leave WAIT_MEM on a return or when the wait expires
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (load_acc) state_nxt = WAIT_MEM;
            WAIT_MEM: if (mem_valid || cnt == CNT_LAST) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Back-pressure and write-port arbitration for this cycle
    always_comb begin
        stall = (load_issue && busy)
              || (alu_valid && buf_full)
              || (alu_valid && busy && alu_rd == pend_rd && alu_rd != 5'd0);
        load_acc    = load_issue && !stall;
        alu_keep    = alu_valid && !stall && alu_rd != 5'd0;
        load_ret    = busy && mem_valid;
        timeout_hit = busy && !mem_valid && cnt == CNT_LAST;
        spurious    = !busy && mem_valid;
        // a suppressed x0 load does not occupy the port
        win_load    = load_ret && pend_rd != 5'd0;
        win_head    = !win_load && !buf_empty;
        win_alu     = !win_load && buf_empty && alu_keep;
        push        = alu_keep && !win_alu;
    end

    // ALU result FIFO for results that lost the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_rd[i]   <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            if (push) begin
                buf_rd[tail]   <= alu_rd;
                buf_data[tail] <= alu_result;
                tail           <= tail + AW'(1);
            end
            if (win_head) begin
                head <= head + AW'(1);
            end
            if (push && !win_head) begin
                count <= count + (AW + 1)'(1);
            end else if (!push && win_head) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // Registered writeback mux controls and data; unselected data holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite      <= 1'b0;
            MemtoReg      <= 1'b0;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            mem_err       <= 1'b0;
        end else begin
            RegWrite <= win_load || win_head || win_alu;
            mem_err  <= mem_err || timeout_hit || spurious;
            if (win_load) begin
                MemtoReg    <= 1'b1;
                wb_rd       <= pend_rd;
                wb_mem_data <= mem_data;
            end else if (win_head) begin
                MemtoReg      <= 1'b0;
                wb_rd         <= buf_rd[head];
                wb_alu_result <= buf_data[head];
            end else if (win_alu) begin
                MemtoReg      <= 1'b0;
                wb_rd         <= alu_rd;
                wb_alu_result <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed checks of wb_sched arbitration, hazards and errors.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_wb_sched;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        load_issue;
    logic [4:0]  load_rd;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        stall;
    logic        RegWrite;
    logic        MemtoReg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data;
    logic        mem_err;

    int checks;
    int failures;

    wb_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_result    (alu_result),
        .load_issue    (load_issue),
        .load_rd       (load_rd),
        .mem_valid     (mem_valid),
        .mem_data      (mem_data),
        .stall         (stall),
        .RegWrite      (RegWrite),
        .MemtoReg      (MemtoReg),
        .wb_rd         (wb_rd),
        .wb_alu_result (wb_alu_result),
        .wb_mem_data   (wb_mem_data),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        alu_valid  = 1'b0;
        alu_rd     = 5'd0;
        alu_result = 32'd0;
        load_issue = 1'b0;
        load_rd    = 5'd0;
        mem_valid  = 1'b0;
        mem_data   = 32'd0;
    endtask

    task automatic test_reset();
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({RegWrite, MemtoReg, wb_rd} !== 7'd0) begin failures++; $display("FAIL rst_ctl got=%0h exp=0", {RegWrite, MemtoReg, wb_rd}); end
        checks++; if (wb_alu_result !== 32'd0) begin failures++; $display("FAIL rst_alu got=%0h exp=0", wb_alu_result); end
        checks++; if (wb_mem_data !== 32'd0) begin failures++; $display("FAIL rst_mem got=%0h exp=0", wb_mem_data); end
        checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", mem_err); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", stall); end
        rst_n = 1'b1;
        tick();
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL rst_idle_we got=%0b exp=0", RegWrite); end
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'd11;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0b exp=0", stall); end
        tick();
        idle_in();
        checks++; if ({RegWrite, MemtoReg, wb_rd} !== {1'b1, 1'b0, 5'd5}) begin failures++; $display("FAIL alu_ctl got=%0h exp=%0h", {RegWrite, MemtoReg, wb_rd}, {1'b1, 1'b0, 5'd5}); end
        checks++; if (wb_alu_result !== 32'd11) begin failures++; $display("FAIL alu_data got=%0d exp=11", wb_alu_result); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL alu_one_cycle got=%0b exp=0", RegWrite); end
    endtask

    task automatic test_load();
        load_issue = 1'b1; load_rd = 5'd7;
        tick();
        idle_in();
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL ld_issue_we got=%0b exp=0", RegWrite); end
        tick();
        tick();
        mem_valid = 1'b1; mem_data = 32'd11111;
        tick();
        idle_in();
        checks++; if ({RegWrite, MemtoReg, wb_rd} !== {1'b1, 1'b1, 5'd7}) begin failures++; $display("FAIL ld_ctl got=%0h exp=%0h", {RegWrite, MemtoReg, wb_rd}, {1'b1, 1'b1, 5'd7}); end
        checks++; if (wb_mem_data !== 32'd11111) begin failures++; $display("FAIL ld_data got=%0d exp=11111", wb_mem_data); end
        checks++; if (wb_alu_result !== 32'd11) begin failures++; $display("FAIL ld_alu_hold got=%0d exp=11", wb_alu_result); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL ld_one_cycle got=%0b exp=0", RegWrite); end
    endtask

    task automatic test_collision();
        load_issue = 1'b1; load_rd = 5'd7;
        tick();
        idle_in();
        tick();
        mem_valid = 1'b1; mem_data = 32'd11111;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'd42;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL col_stall got=%0b exp=0", stall); end
        tick();
        idle_in();
        checks++; if ({RegWrite, MemtoReg, wb_rd} !== {1'b1, 1'b1, 5'd7}) begin failures++; $display("FAIL col_load_first got=%0h exp=%0h", {RegWrite, MemtoReg, wb_rd}, {1'b1, 1'b1, 5'd7}); end
        tick();
        checks++; if ({RegWrite, MemtoReg, wb_rd} !== {1'b1, 1'b0, 5'd3}) begin failures++; $display("FAIL col_alu_next got=%0h exp=%0h", {RegWrite, MemtoReg, wb_rd}, {1'b1, 1'b0, 5'd3}); end
        checks++; if ({wb_alu_result, wb_mem_data} !== {32'd42, 32'd11111}) begin failures++; $display("FAIL col_data got=%0d/%0d exp=42/11111", wb_alu_result, wb_mem_data); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL col_done got=%0b exp=0", RegWrite); end
    endtask

    task automatic test_buffer_full();
        load_issue = 1'b1; load_rd = 5'd7;
        tick();
        idle_in();
        mem_valid = 1'b1; mem_data = 32'h111;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_result = 32'hA1;
        tick();
        idle_in();
        checks++; if ({RegWrite, MemtoReg, wb_rd, wb_mem_data} !== {1'b1, 1'b1, 5'd7, 32'h111}) begin failures++; $display("FAIL bf_w0 got=%0h", {RegWrite, MemtoReg, wb_rd, wb_mem_data}); end
        load_issue = 1'b1; load_rd = 5'd8;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 32'hA2;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL bf_dual_stall got=%0b exp=0", stall); end
        tick();
        idle_in();
        checks++; if ({RegWrite, MemtoReg, wb_rd, wb_alu_result} !== {1'b1, 1'b0, 5'd1, 32'hA1}) begin failures++; $display("FAIL bf_w1 got=%0h", {RegWrite, MemtoReg, wb_rd, wb_alu_result}); end
        mem_valid = 1'b1; mem_data = 32'h222;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'hA3;
        tick();
        idle_in();
        checks++; if ({RegWrite, MemtoReg, wb_rd, wb_mem_data} !== {1'b1, 1'b1, 5'd8, 32'h222}) begin failures++; $display("FAIL bf_w2 got=%0h", {RegWrite, MemtoReg, wb_rd, wb_mem_data}); end
        alu_valid = 1'b1; alu_rd = 5'd4; alu_result = 32'hA4;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL bf_full_stall got=%0b exp=1", stall); end
        tick();
        checks++; if ({RegWrite, MemtoReg, wb_rd, wb_alu_result} !== {1'b1, 1'b0, 5'd2, 32'hA2}) begin failures++; $display("FAIL bf_fifo0 got=%0h", {RegWrite, MemtoReg, wb_rd, wb_alu_result}); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL bf_unstall got=%0b exp=0", stall); end
        tick();
        idle_in();
        checks++; if ({RegWrite, MemtoReg, wb_rd, wb_alu_result} !== {1'b1, 1'b0, 5'd3, 32'hA3}) begin failures++; $display("FAIL bf_fifo1 got=%0h", {RegWrite, MemtoReg, wb_rd, wb_alu_result}); end
        tick();
        checks++; if ({RegWrite, MemtoReg, wb_rd, wb_alu_result} !== {1'b1, 1'b0, 5'd4, 32'hA4}) begin failures++; $display("FAIL bf_fifo2 got=%0h", {RegWrite, MemtoReg, wb_rd, wb_alu_result}); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL bf_drained got=%0b exp=0", RegWrite); end
    endtask

    task automatic test_hazards();
        load_issue = 1'b1; load_rd = 5'd9;
        tick();
        idle_in();
        load_issue = 1'b1; load_rd = 5'd10;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL hz_load_stall got=%0b exp=1", stall); end
        idle_in();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'd5;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL hz_waw_stall got=%0b exp=1", stall); end
        tick();
        checks++; if ({RegWrite, stall} !== 2'b01) begin failures++; $display("FAIL hz_waw_hold got=%0b exp=01", {RegWrite, stall}); end
        mem_valid = 1'b1; mem_data = 32'h99;
        tick();
        mem_valid = 1'b0; mem_data = 32'd0;
        checks++; if ({RegWrite, MemtoReg, wb_rd, wb_mem_data} !== {1'b1, 1'b1, 5'd9, 32'h99}) begin failures++; $display("FAIL hz_ret got=%0h", {RegWrite, MemtoReg, wb_rd, wb_mem_data}); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hz_release got=%0b exp=0", stall); end
        tick();
        idle_in();
        checks++; if ({RegWrite, MemtoReg, wb_rd, wb_alu_result} !== {1'b1, 1'b0, 5'd9, 32'd5}) begin failures++; $display("FAIL hz_alu_after got=%0h", {RegWrite, MemtoReg, wb_rd, wb_alu_result}); end
        alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'd77;
        tick();
        idle_in();
        checks++; if ({RegWrite, wb_alu_result} !== {1'b0, 32'd5}) begin failures++; $display("FAIL hz_x0 got=%0h", {RegWrite, wb_alu_result}); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL hz_x0_late got=%0b exp=0", RegWrite); end
    endtask

    task automatic test_timeout_edge();
        load_issue = 1'b1; load_rd = 5'd12;
        tick();
        idle_in();
        repeat (15) tick();
        checks++; if ({mem_err, RegWrite} !== 2'b00) begin failures++; $display("FAIL te_pre got=%0b exp=00", {mem_err, RegWrite}); end
        mem_valid = 1'b1; mem_data = 32'h5A;
        tick();
        idle_in();
        checks++; if ({RegWrite, MemtoReg, wb_rd, wb_mem_data} !== {1'b1, 1'b1, 5'd12, 32'h5A}) begin failures++; $display("FAIL te_ret got=%0h", {RegWrite, MemtoReg, wb_rd, wb_mem_data}); end
        checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL te_no_err got=%0b exp=0", mem_err); end
    endtask

    task automatic test_timeout();
        load_issue = 1'b1; load_rd = 5'd13;
        tick();
        idle_in();
        repeat (15) tick();
        load_issue = 1'b1; load_rd = 5'd14;
        #1;
        checks++; if ({mem_err, stall} !== 2'b01) begin failures++; $display("FAIL to_wait got=%0b exp=01", {mem_err, stall}); end
        idle_in();
        tick();
        checks++; if ({mem_err, RegWrite} !== 2'b10) begin failures++; $display("FAIL to_err got=%0b exp=10", {mem_err, RegWrite}); end
        load_issue = 1'b1; load_rd = 5'd14;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL to_idle got=%0b exp=0", stall); end
        tick();
        idle_in();
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({RegWrite, MemtoReg, wb_rd, mem_err} !== 8'd0) begin failures++; $display("FAIL rm_ctl got=%0h exp=0", {RegWrite, MemtoReg, wb_rd, mem_err}); end
        checks++; if ({wb_alu_result, wb_mem_data} !== 64'd0) begin failures++; $display("FAIL rm_data got=%0h exp=0", {wb_alu_result, wb_mem_data}); end
        tick();
        rst_n = 1'b1;
        mem_valid = 1'b1; mem_data = 32'h77;
        tick();
        idle_in();
        checks++; if ({mem_err, RegWrite} !== 2'b10) begin failures++; $display("FAIL sp_err got=%0b exp=10", {mem_err, RegWrite}); end
        checks++; if (wb_mem_data !== 32'd0) begin failures++; $display("FAIL sp_data got=%0h exp=0", wb_mem_data); end
        tick();
        checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL sp_sticky got=%0b exp=1", mem_err); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_in();
        test_reset();
        test_alu();
        test_load();
        test_collision();
        test_buffer_full();
        test_hazards();
        test_timeout_edge();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
